// File: rtl/uart_rx_mv.sv
// Oversampling UART receiver: 2-flop line synchronizer, 3-sample majority vote per bit,
// optional parity and 1 or 2 stop bits. The frame ends on the last stop-bit vote.
module uart_rx_mv #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_data,
    input  logic                 baud_tick,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_rx_done,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [TW-1:0] TICK_LO   = TW'(M - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(M);
    localparam logic [TW-1:0] TICK_HI   = TW'(M + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);
    localparam logic          PAR_EN    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic word_parity(input logic [DATA_BITS-1:0] w);
        return ^w;
    endfunction

    state_t                 state_q, state_d;
    logic [1:0]             sync_q, sync_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [3:0]             bit_q, bit_d;
    logic [1:0]             samp_q, samp_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_acc_q, perr_acc_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   done_q, done_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   rx_s;
    logic                   vote_s;

    assign rx_s   = sync_q[1];
    // Vote resolves on the M+1 tick using the two earlier stored samples and the current line.
    assign vote_s = vote3(samp_q[0], samp_q[1], rx_s);

    // Next-state, counters, shift register and output register updates.
    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], rx_data};
        tick_d     = tick_q;
        bit_d      = bit_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;

        if (baud_tick) begin
            tick_d = tick_q + TW'(1);
            if (tick_q == TICK_LO) begin
                samp_d[0] = rx_s;
            end else if (tick_q == TICK_MID) begin
                samp_d[1] = rx_s;
            end else begin
                samp_d = samp_q;
            end

            case (state_q)
                IDLE: begin
                    tick_d = '0;
                    if (!rx_s) begin
                        state_d    = START;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (tick_q == TICK_HI && vote_s) begin
                        state_d = IDLE;
                        tick_d  = '0;
                    end else if (tick_q == TICK_LAST) begin
                        state_d = DATA;
                        tick_d  = '0;
                        bit_d   = 4'd0;
                    end else begin
                        state_d = START;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_HI) begin
                        shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = PAR_EN ? PARITY : STOP;
                            bit_d   = 4'd0;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                PARITY: begin
                    if (tick_q == TICK_HI) begin
                        perr_acc_d = (word_parity(shift_q) ^ vote_s) != PAR_ODD;
                    end else if (tick_q == TICK_LAST) begin
                        state_d = STOP;
                        tick_d  = '0;
                        bit_d   = 4'd0;
                    end else begin
                        perr_acc_d = perr_acc_q;
                    end
                end
                STOP: begin
                    // Leave on the last stop vote so a start edge half a bit later is caught.
                    if (tick_q == TICK_HI) begin
                        if (bit_q == STOP_LAST) begin
                            state_d = IDLE;
                            tick_d  = '0;
                            done_d  = 1'b1;
                            dout_d  = shift_q;
                            perr_d  = PAR_EN ? perr_acc_q : 1'b0;
                            ferr_d  = ferr_acc_q | ~vote_s;
                        end else begin
                            ferr_acc_d = ferr_acc_q | ~vote_s;
                        end
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        bit_d  = bit_q + 4'd1;
                    end else begin
                        ferr_acc_d = ferr_acc_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end else begin
            tick_d = tick_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sync_q     <= 2'b11;
            tick_q     <= '0;
            bit_q      <= 4'd0;
            samp_q     <= 2'b00;
            shift_q    <= '0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign o_dout       = dout_q;
    assign o_rx_done    = done_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_mv.sv
// Directed bench for uart_rx_mv: three instances (8N1, 8E1, 7N2) sharing clk, rst and baud_tick.
module tb_uart_rx_mv;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic [1:0] div_q = 2'd0;
    logic       rx_line [3];

    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic       done0, done1, done2;
    logic       perr0, perr1, perr2;
    logic       ferr0, ferr1, ferr2;
    logic       busy0, busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt0 = 0, done_cnt1 = 0, done_cnt2 = 0;
    int busy_cyc0 = 0;
    logic [6:0] prev2 = 7'd0, last2 = 7'd0;

    uart_rx_mv u_dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_line[0]), .baud_tick(baud_tick),
        .o_dout(dout0), .o_rx_done(done0), .o_parity_err(perr0),
        .o_frame_err(ferr0), .o_busy(busy0)
    );

    uart_rx_mv #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .rst(rst), .rx_data(rx_line[1]), .baud_tick(baud_tick),
        .o_dout(dout1), .o_rx_done(done1), .o_parity_err(perr1),
        .o_frame_err(ferr1), .o_busy(busy1)
    );

    uart_rx_mv #(.DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .rx_data(rx_line[2]), .baud_tick(baud_tick),
        .o_dout(dout2), .o_rx_done(done2), .o_parity_err(perr2),
        .o_frame_err(ferr2), .o_busy(busy2)
    );

    always #5 clk = ~clk;

    // baud_tick one clk in four, changed on the falling edge so it is stable at posedge.
    always @(negedge clk) begin
        div_q     <= div_q + 2'd1;
        baud_tick <= (div_q == 2'd3);
    end

    always @(posedge clk) begin
        if (done0) done_cnt0 <= done_cnt0 + 1;
        if (busy0) busy_cyc0 <= busy_cyc0 + 1;
    end

    always @(posedge clk) begin
        if (done1) done_cnt1 <= done_cnt1 + 1;
    end

    always @(posedge clk) begin
        if (done2) begin
            done_cnt2 <= done_cnt2 + 1;
            prev2     <= last2;
            last2     <= dout2;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (baud_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    // Drives one frame; glitch_bit inverts only the middle sample of that bit, rst_bit aborts there.
    task automatic send(input int sel, input logic [8:0] data, input int nbits,
                        input bit has_par, input logic par_bit, input int nstop,
                        input logic stop_val, input int glitch_bit, input int rst_bit);
        logic b;
        wait_ticks(1);
        rx_line[sel] = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            b = data[i];
            rx_line[sel] = b;
            if (i == rst_bit) begin
                wait_ticks(4);
                rst = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                rx_line[sel] = 1'b1;
                return;
            end
            if (i == glitch_bit) begin
                wait_ticks(9);
                rx_line[sel] = ~b;
                wait_ticks(1);
                rx_line[sel] = b;
                wait_ticks(6);
            end else begin
                wait_ticks(16);
            end
        end
        if (has_par) begin
            rx_line[sel] = par_bit;
            wait_ticks(16);
        end
        for (int s = 0; s < nstop; s++) begin
            rx_line[sel] = stop_val;
            wait_ticks(16);
        end
        rx_line[sel] = 1'b1;
    endtask

    initial begin
        int base;
        rx_line[0] = 1'b1;
        rx_line[1] = 1'b1;
        rx_line[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_dout", dout0, 8'h00);
        check_eq("rst_done", done0, 1'b0);
        check_eq("rst_busy", busy0, 1'b0);
        check_eq("rst_perr", perr0, 1'b0);
        check_eq("rst_ferr", ferr0, 1'b0);
        rst = 1'b0;
        wait_ticks(4);

        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1, -1);
        wait_ticks(4);
        check_eq("a5_done_cnt", done_cnt0, 1);
        check_eq("a5_dout", dout0, 8'hA5);
        check_eq("a5_perr", perr0, 1'b0);
        check_eq("a5_ferr", ferr0, 1'b0);
        check_eq("a5_busy", busy0, 1'b0);

        send(1, 9'h007, 8, 1'b1, 1'b0, 1, 1'b1, -1, -1);
        wait_ticks(4);
        check_eq("par0_done_cnt", done_cnt1, 1);
        check_eq("par0_dout", dout1, 8'h07);
        check_eq("par0_perr", perr1, 1'b1);
        send(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b1, -1, -1);
        wait_ticks(4);
        check_eq("par1_done_cnt", done_cnt1, 2);
        check_eq("par1_perr", perr1, 1'b0);
        check_eq("par1_ferr", ferr1, 1'b0);

        send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0, -1, -1);
        wait_ticks(40);
        check_eq("ferr_done_cnt", done_cnt0, 2);
        check_eq("ferr_dout", dout0, 8'h3C);
        check_eq("ferr_flag", ferr0, 1'b1);
        send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, -1, -1);
        wait_ticks(4);
        check_eq("clean_done_cnt", done_cnt0, 3);
        check_eq("clean_dout", dout0, 8'h11);
        check_eq("clean_ferr", ferr0, 1'b0);
        check_eq("clean_perr_n1", perr0, 1'b0);

        base = busy_cyc0;
        wait_ticks(1);
        rx_line[0] = 1'b0;
        wait_ticks(3);
        rx_line[0] = 1'b1;
        wait_ticks(24);
        check_eq("glitch_busy_seen", (busy_cyc0 > base), 1'b1);
        check_eq("glitch_busy_end", busy0, 1'b0);
        check_eq("glitch_no_done", done_cnt0, 3);

        send(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1, 2, -1);
        wait_ticks(4);
        check_eq("vote_done_cnt", done_cnt0, 4);
        check_eq("vote_dout", dout0, 8'h5A);

        send(2, 9'h055, 7, 1'b0, 1'b0, 2, 1'b1, -1, -1);
        send(2, 9'h02A, 7, 1'b0, 1'b0, 2, 1'b1, -1, -1);
        wait_ticks(4);
        check_eq("b2b_done_cnt", done_cnt2, 2);
        check_eq("b2b_first", prev2, 7'h55);
        check_eq("b2b_second", last2, 7'h2A);
        check_eq("b2b_ferr", ferr2, 1'b0);

        send(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1, -1, 3);
        wait_ticks(30);
        check_eq("abort_no_done", done_cnt0, 4);
        check_eq("abort_busy", busy0, 1'b0);
        check_eq("abort_dout_clr", dout0, 8'h00);
        send(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1, -1, -1);
        wait_ticks(4);
        check_eq("after_rst_done_cnt", done_cnt0, 5);
        check_eq("after_rst_dout", dout0, 8'h81);
        check_eq("after_rst_ferr", ferr0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
